i2c_rx_capture: RTL and testbench

I2C_RX_CAPTURE -- requirements
Module: i2c_rx_capture

---
 rtl/i2c_rx_capture_pkg.sv | 21 ++
 rtl/i2c_rx_fifo.sv | 67 ++++++
 rtl/i2c_rx_capture.sv | 152 +++++++++++++++
 tb/tb_i2c_rx_capture.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_rx_capture_pkg.sv
// ============================================================================
// i2c_rx_capture_pkg : shared FSM encodings and parameter defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package i2c_rx_capture_pkg;

  localparam int unsigned C_TIMEOUT_CYCLES_DEF = 1024;
  localparam int unsigned C_FIFO_DEPTH_DEF     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STORE = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_rx_fifo.sv
// ============================================================================
// i2c_rx_fifo : 8-bit first-word-fall-through FIFO, writes dropped when full
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  output logic [7:0] rd_data_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_wr_ok, w_rd_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(FIFO_DEPTH));
  assign w_wr_ok   = wr_en_i && !full_o;
  assign w_rd_ok   = rd_en_i && !empty_o;
  // Head is masked so the output reads zero whenever nothing is buffered.
  assign rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({w_wr_ok, w_rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/i2c_rx_capture.sv
// ============================================================================
// i2c_rx_capture : serial byte capture with watchdog and FWFT output FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_rx_capture
  import i2c_rx_capture_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES_DEF,
  parameter int unsigned FIFO_DEPTH     = C_FIFO_DEPTH_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic       SCLK_IN,
  input  logic       SDA_IN,
  input  logic       RD_EN,
  input  logic       CLR_ERR,
  output logic [7:0] DOUT,
  output logic       EMPTY,
  output logic       FULL,
  output logic       BYTE_DONE,
  output logic       FRAME_ERR,
  output logic       OVERFLOW
);

  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] C_WDOG_LIM = WDW'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  logic           sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic           sda_s1_q, sda_s2_q;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           overflow_q, overflow_d;
  logic           w_rise, w_fifo_wr, w_drop;

  assign w_rise = sclk_s2_q & ~sclk_prev_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      sda_s1_q    <= 1'b0;
      sda_s2_q    <= 1'b0;
    end else begin
      sclk_s1_q   <= SCLK_IN;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sda_s1_q    <= SDA_IN;
      sda_s2_q    <= sda_s1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    wdog_d    = wdog_q;
    BYTE_DONE = 1'b0;
    FRAME_ERR = 1'b0;
    w_fifo_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (ENABLE && w_rise) begin
          shreg_d  = {shreg_q[6:0], sda_s2_q};
          bitcnt_d = 3'd1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!ENABLE) begin
          shreg_d  = '0;
          bitcnt_d = '0;
          wdog_d   = '0;
          state_d  = ST_IDLE;
        end else if (w_rise) begin
          shreg_d  = {shreg_q[6:0], sda_s2_q};
          bitcnt_d = bitcnt_q + 3'd1;
          wdog_d   = '0;
          if (bitcnt_q == 3'd7) state_d = ST_STORE;
        end else if (wdog_q == C_WDOG_LIM) begin
          state_d = ST_ERROR;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      ST_STORE: begin
        // The FIFO itself refuses the write when full; w_drop records it.
        BYTE_DONE = 1'b1;
        w_fifo_wr = 1'b1;
        shreg_d   = '0;
        bitcnt_d  = '0;
        state_d   = ST_IDLE;
      end
      ST_ERROR: begin
        FRAME_ERR = ENABLE;
        shreg_d   = '0;
        bitcnt_d  = '0;
        wdog_d    = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_drop = (state_q == ST_STORE) && FULL;

  always_comb begin
    overflow_d = overflow_q;
    if (w_drop)       overflow_d = 1'b1;
    else if (CLR_ERR) overflow_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      wdog_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      wdog_q     <= wdog_d;
      overflow_q <= overflow_d;
    end
  end

  assign OVERFLOW = overflow_q;

  i2c_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .wr_en_i   (w_fifo_wr),
    .wr_data_i (shreg_q),
    .rd_en_i   (RD_EN),
    .rd_data_o (DOUT),
    .empty_o   (EMPTY),
    .full_o    (FULL)
  );

endmodule

`default_nettype wire

// File: tb/tb_i2c_rx_capture.sv
// ============================================================================
// tb_i2c_rx_capture : directed self-checking bench for i2c_rx_capture
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_rx_capture;

  logic       CLK = 1'b0;
  logic       RST_N, ENABLE, SCLK_IN, SDA_IN, RD_EN, CLR_ERR;
  logic [7:0] DOUT;
  logic       EMPTY, FULL, BYTE_DONE, FRAME_ERR, OVERFLOW;

  int n_checks = 0;
  int n_fails  = 0;
  int bd_cnt   = 0;
  int fe_cnt   = 0;
  int bd_base, fe_base;

  i2c_rx_capture #(
    .TIMEOUT_CYCLES (1024),
    .FIFO_DEPTH     (4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ENABLE    (ENABLE),
    .SCLK_IN   (SCLK_IN),
    .SDA_IN    (SDA_IN),
    .RD_EN     (RD_EN),
    .CLR_ERR   (CLR_ERR),
    .DOUT      (DOUT),
    .EMPTY     (EMPTY),
    .FULL      (FULL),
    .BYTE_DONE (BYTE_DONE),
    .FRAME_ERR (FRAME_ERR),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (BYTE_DONE === 1'b1) bd_cnt++;
    if (FRAME_ERR === 1'b1) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    SDA_IN = b;
    repeat (4) @(negedge CLK);
    SCLK_IN = 1'b1;
    repeat (4) @(negedge CLK);
    SCLK_IN = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge CLK);
    check(tag, {24'd0, DOUT}, {24'd0, exp});
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; ENABLE = 1'b0; SCLK_IN = 1'b0; SDA_IN = 1'b0;
    RD_EN = 1'b0; CLR_ERR = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_dout",     {24'd0, DOUT}, 32'h00);
    check("rst_empty",    EMPTY, 1);
    check("rst_full",     FULL, 0);
    check("rst_bytedone", BYTE_DONE, 0);
    check("rst_frameerr", FRAME_ERR, 0);
    check("rst_overflow", OVERFLOW, 0);
    RST_N = 1'b1;
    ENABLE = 1'b1;
    repeat (3) @(negedge CLK);

    // 0xA5 single byte
    bd_base = bd_cnt;
    send_bits(8'hA5, 8);
    check("a5_bytedone_cnt", bd_cnt - bd_base, 1);
    check("a5_empty", EMPTY, 0);
    pop_check("a5_dout", 8'hA5);
    check("a5_empty_after_pop", EMPTY, 1);

    // timeout abandonment then 0x3C
    fe_base = fe_cnt;
    send_bits(8'hE0, 3);
    repeat (1100) @(negedge CLK);
    check("to_frameerr_cnt", fe_cnt - fe_base, 1);
    check("to_empty", EMPTY, 1);
    send_bits(8'h3C, 8);
    check("to_3c_empty", EMPTY, 0);
    pop_check("to_3c_dout", 8'h3C);

    // fill to full then overflow
    for (int i = 1; i <= 3; i++) send_bits(8'(i), 8);
    check("fill3_full", FULL, 0);
    send_bits(8'h04, 8);
    check("fill4_full", FULL, 1);
    check("fill4_overflow", OVERFLOW, 0);
    send_bits(8'h05, 8);
    check("fill5_overflow", OVERFLOW, 1);
    for (int i = 1; i <= 4; i++) pop_check("fifo_order", 8'(i));
    check("fifo_drained_empty", EMPTY, 1);
    check("overflow_sticky", OVERFLOW, 1);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    check("overflow_cleared", OVERFLOW, 0);

    // ENABLE drop mid-byte, then 0xFF
    fe_base = fe_cnt;
    send_bits(8'hAA, 5);
    ENABLE = 1'b0;
    repeat (5) @(negedge CLK);
    ENABLE = 1'b1;
    repeat (2) @(negedge CLK);
    send_bits(8'hFF, 8);
    pop_check("en_ff_dout", 8'hFF);
    check("en_only_one_byte", EMPTY, 1);
    check("en_no_frameerr", fe_cnt - fe_base, 0);

    // reset mid-byte with two bytes buffered
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    check("rb_buffered", EMPTY, 0);
    fe_base = fe_cnt;
    send_bits(8'h55, 4);
    RST_N = 1'b0;
    @(negedge CLK);
    check("rb_empty", EMPTY, 1);
    check("rb_dout", {24'd0, DOUT}, 32'h00);
    check("rb_full", FULL, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    send_bits(8'h81, 8);
    check("rb_no_frameerr", fe_cnt - fe_base, 0);
    pop_check("rb_81_dout", 8'h81);
    check("rb_81_empty", EMPTY, 1);

    // pop coincident with BYTE_DONE at occupancy 2
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 7);
    SDA_IN = 1'b1;
    repeat (4) @(negedge CLK);
    SCLK_IN = 1'b1;
    begin
      int k;
      for (k = 0; k < 40 && BYTE_DONE !== 1'b1; k++) @(negedge CLK);
      check("sim_bytedone_seen", BYTE_DONE, 1);
    end
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
    SCLK_IN = 1'b0;
    repeat (4) @(negedge CLK);
    check("sim_full", FULL, 0);
    pop_check("sim_head_22", 8'h22);
    pop_check("sim_next_33", 8'h33);
    check("sim_empty", EMPTY, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
